// File: rtl/game_ctrl_pio_out_if.sv
// Avalon-MM slave bus bundle for the game control output PIO.
// Latency: none (wires only); readdata is registered inside the slave.
// Backpressure: none; no waitrequest, every transfer completes in one cycle.
interface game_ctrl_pio_out_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/game_ctrl_pio_out.sv
// Output PIO: level bits (out_port) and self-timed strobes (pulse_port) for the game logic.
// Latency: outputs update one cycle after the write edge; readdata is valid one cycle after address.
// Backpressure: none; writes are accepted every cycle, strobes retrigger instead of queueing.
module game_ctrl_pio_out #(
   parameter int WIDTH        = 8,
   parameter int PULSE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   game_ctrl_pio_out_if.slave    bus,
   output logic [WIDTH-1:0]      out_port,
   output logic [WIDTH-1:0]      pulse_port
);

   localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PULSE_CYCLES - 1);

   localparam logic [1:0] ADDR_DATA  = 2'd0;
   localparam logic [1:0] ADDR_PULSE = 2'd1;
   localparam logic [1:0] ADDR_SET   = 2'd2;
   localparam logic [1:0] ADDR_CLEAR = 2'd3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      readdata_q, readdata_d;

   logic             wr;
   logic             pulse_wr;
   logic [WIDTH-1:0] wd;
   logic             unused_bits;

   assign wr       = bus.chipselect & ~bus.write_n;
   assign wd       = bus.writedata[WIDTH-1:0];
   // A zero write to PULSE is a no-op, so only non-zero data arms or extends a strobe.
   assign pulse_wr = wr && (bus.address == ADDR_PULSE) && (wd != '0);

   // Bits above WIDTH are ignored by design.
   assign unused_bits = ^bus.writedata;

   // Level register: direct load, bitwise set and bitwise clear.
   always_comb begin
      data_d = data_q;
      if (wr) begin
         case (bus.address)
            ADDR_DATA:  data_d = wd;
            ADDR_SET:   data_d = data_q | wd;
            ADDR_CLEAR: data_d = data_q & ~wd;
            default:    data_d = data_q;
         endcase
      end
   end

   // Readback mux; sampled every cycle so a same-cycle write returns the old value.
   always_comb begin
      readdata_d = 32'h0;
      case (bus.address)
         ADDR_DATA:  readdata_d = 32'(data_q);
         ADDR_PULSE: readdata_d = 32'(pulse_q);
         default:    readdata_d = 32'h0;
      endcase
   end

   // Strobe FSM: a retrigger on the final cycle wins over expiry and reloads the count.
   always_comb begin
      state_d = state_q;
      pulse_d = pulse_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pulse_wr) begin
               pulse_d = wd;
               cnt_d   = CNT_RELOAD;
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (pulse_wr) begin
               pulse_d = pulse_q | wd;
               cnt_d   = CNT_RELOAD;
            end else if (cnt_q == '0) begin
               pulse_d = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            pulse_d = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; everything clears asynchronously so strobes drop at once on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         data_q     <= '0;
         pulse_q    <= '0;
         cnt_q      <= '0;
         readdata_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         pulse_q    <= pulse_d;
         cnt_q      <= cnt_d;
         readdata_q <= readdata_d;
      end
   end

   assign out_port     = data_q;
   assign pulse_port   = pulse_q;
   assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_game_ctrl_pio_out.sv
// Bench for the game control output PIO: register map, readback latency and strobe timing.
// Latency: bus inputs change 1 ns after a rising edge and outputs are sampled at the same point.
// Backpressure: none on this bus; expected readback values queue per driven cycle.
module tb_game_ctrl_pio_out;
   localparam int W = 8;
   localparam int P = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] out_port;
   logic [W-1:0] pulse_port;

   game_ctrl_pio_out_if bus();

   game_ctrl_pio_out #(.WIDTH(W), .PULSE_CYCLES(P)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .out_port   (out_port),
      .pulse_port (pulse_port)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [W-1:0] m_data;
   logic [W-1:0] m_pulse;   // strobe value visible before the coming edge, kept by each test

   function automatic logic [31:0] rd_model(input logic [1:0] a);
      case (a)
         2'd0:    return {24'h0, m_data};
         2'd1:    return {24'h0, m_pulse};
         default: return 32'h0;
      endcase
   endfunction

   // Drive one bus cycle, queue the readback expected one cycle later, update the level model.
   task automatic drive(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] d);
      bus.address    = a;
      bus.chipselect = cs;
      bus.write_n    = wn;
      bus.writedata  = d;
      exp_q.push_back(rd_model(a));
      if (cs && !wn) begin
         case (a)
            2'd0:    m_data = d[W-1:0];
            2'd2:    m_data = m_data | d[W-1:0];
            2'd3:    m_data = m_data & ~d[W-1:0];
            default: m_data = m_data;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] e;
      reset_n = 1'b0;
      bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h exp %h", bus.readdata, 32'h0); end
      checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL reset_out_port got %h exp %h", out_port, 8'h00); end
      checks++; if (pulse_port !== 8'h00) begin errors++; $display("FAIL reset_pulse_port got %h exp %h", pulse_port, 8'h00); end
      reset_n = 1'b1;
      m_data = '0;
      m_pulse = '0;
      for (int i = 0; i < 5; i++) begin
         drive(2'd0, 1'b0, 1'b1, 32'h0);
         e = exp_q.pop_front();
         checks++; if (bus.readdata !== e) begin errors++; $display("FAIL idle_readdata[%0d] got %h exp %h", i, bus.readdata, e); end
         checks++; if ({out_port, pulse_port} !== 16'h0) begin errors++; $display("FAIL idle_ports[%0d] got %h exp %h", i, {out_port, pulse_port}, 16'h0); end
      end
   endtask

   task automatic test_data_write();
      logic [31:0] e;
      // Upper writedata bits must be ignored; same-cycle readback returns the old value.
      drive(2'd0, 1'b1, 1'b0, 32'h1234_56A5);
      e = exp_q.pop_front();
      checks++; if (bus.readdata !== e) begin errors++; $display("FAIL data_wr_readdata got %h exp %h", bus.readdata, e); end
      checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL data_out_port got %h exp %h", out_port, 8'hA5); end
      drive(2'd0, 1'b0, 1'b1, 32'h0);
      e = exp_q.pop_front();
      checks++; if (bus.readdata !== 32'h0000_00A5) begin errors++; $display("FAIL data_readback got %h exp %h", bus.readdata, 32'h0000_00A5); end
      checks++; if (bus.readdata !== e) begin errors++; $display("FAIL data_readback_sb got %h exp %h", bus.readdata, e); end
      // write_n low without chipselect is not a write.
      drive(2'd0, 1'b0, 1'b0, 32'h0000_0011);
      e = exp_q.pop_front();
      checks++; if (bus.readdata !== e) begin errors++; $display("FAIL nocs_readdata got %h exp %h", bus.readdata, e); end
      checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL nocs_out_port got %h exp %h", out_port, 8'hA5); end
   endtask

   task automatic test_set_clear();
      logic [1:0]  op_a [3] = '{2'd0, 2'd2, 2'd3};
      logic [31:0] op_d [3] = '{32'hF0, 32'h0F, 32'h81};
      logic [7:0]  op_e [3] = '{8'hF0, 8'hFF, 8'h7E};
      logic [1:0]  rd_a [3] = '{2'd2, 2'd3, 2'd0};
      logic [31:0] e;
      for (int i = 0; i < 3; i++) begin
         drive(op_a[i], 1'b1, 1'b0, op_d[i]);
         e = exp_q.pop_front();
         checks++; if (bus.readdata !== e) begin errors++; $display("FAIL setclr_readdata[%0d] got %h exp %h", i, bus.readdata, e); end
         checks++; if (out_port !== op_e[i]) begin errors++; $display("FAIL setclr_out_port[%0d] got %h exp %h", i, out_port, op_e[i]); end
      end
      for (int i = 0; i < 3; i++) begin
         drive(rd_a[i], 1'b0, 1'b1, 32'h0);
         e = exp_q.pop_front();
         checks++; if (bus.readdata !== e) begin errors++; $display("FAIL setclr_read@%0d got %h exp %h", rd_a[i], bus.readdata, e); end
      end
   endtask

   task automatic test_pulse();
      logic [31:0] e;
      logic [7:0]  exp_p;
      m_pulse = 8'h00;
      drive(2'd1, 1'b1, 1'b0, 32'h03);
      e = exp_q.pop_front();
      checks++; if (bus.readdata !== e) begin errors++; $display("FAIL pulse_wr_readdata got %h exp %h", bus.readdata, e); end
      checks++; if (pulse_port !== 8'h03) begin errors++; $display("FAIL pulse_start got %h exp %h", pulse_port, 8'h03); end
      checks++; if (out_port !== m_data) begin errors++; $display("FAIL pulse_keeps_data got %h exp %h", out_port, m_data); end
      m_pulse = 8'h03;
      for (int i = 1; i <= 4; i++) begin
         drive(2'd1, 1'b0, 1'b1, 32'h0);
         exp_p = (i < 4) ? 8'h03 : 8'h00;
         e = exp_q.pop_front();
         checks++; if (bus.readdata !== e) begin errors++; $display("FAIL pulse_read[%0d] got %h exp %h", i, bus.readdata, e); end
         checks++; if (pulse_port !== exp_p) begin errors++; $display("FAIL pulse_len[%0d] got %h exp %h", i, pulse_port, exp_p); end
      end
      m_pulse = 8'h00;
      drive(2'd1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) drive(2'd1, 1'b0, 1'b1, 32'h0);
         e = exp_q.pop_front();
         checks++; if (bus.readdata !== e) begin errors++; $display("FAIL zero_pulse_read[%0d] got %h exp %h", i, bus.readdata, e); end
         checks++; if (pulse_port !== 8'h00) begin errors++; $display("FAIL zero_pulse[%0d] got %h exp %h", i, pulse_port, 8'h00); end
      end
   endtask

   task automatic test_retrigger();
      logic [31:0] e;
      logic [7:0]  seq [9] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h05, 8'h05, 8'h05, 8'h05, 8'h00};
      int          bit0_high = 0;
      for (int i = 0; i < 9; i++) begin
         m_pulse = (i == 0) ? 8'h00 : seq[i-1];
         if (i == 0)      drive(2'd1, 1'b1, 1'b0, 32'h01);
         else if (i == 4) drive(2'd1, 1'b1, 1'b0, 32'h04);   // lands on the final count
         else             drive(2'd0, 1'b0, 1'b1, 32'h0);
         e = exp_q.pop_front();
         checks++; if (bus.readdata !== e) begin errors++; $display("FAIL retrig_read[%0d] got %h exp %h", i, bus.readdata, e); end
         checks++; if (pulse_port !== seq[i]) begin errors++; $display("FAIL retrig_pulse[%0d] got %h exp %h", i, pulse_port, seq[i]); end
         if (pulse_port[0]) bit0_high++;
      end
      m_pulse = 8'h00;
      checks++; if (bit0_high !== 8) begin errors++; $display("FAIL retrig_bit0_cycles got %0d exp %0d", bit0_high, 8); end
   endtask

   task automatic test_reset_mid_pulse();
      logic [31:0] e;
      logic [7:0]  exp_p;
      m_pulse = 8'h00;
      drive(2'd1, 1'b1, 1'b0, 32'h0F);
      e = exp_q.pop_front();
      m_pulse = 8'h0F;
      drive(2'd0, 1'b0, 1'b1, 32'h0);
      e = exp_q.pop_front();
      checks++; if (pulse_port !== 8'h0F) begin errors++; $display("FAIL midrst_pre got %h exp %h", pulse_port, 8'h0F); end
      reset_n = 1'b0;
      #2;
      checks++; if (pulse_port !== 8'h00) begin errors++; $display("FAIL midrst_pulse_async got %h exp %h", pulse_port, 8'h00); end
      checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL midrst_out_async got %h exp %h", out_port, 8'h00); end
      checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL midrst_readdata_async got %h exp %h", bus.readdata, 32'h0); end
      exp_q.delete();
      m_data = '0;
      m_pulse = '0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) drive(2'd1, 1'b1, 1'b0, 32'h02);
         else        drive(2'd0, 1'b0, 1'b1, 32'h0);
         exp_p = (i < 4) ? 8'h02 : 8'h00;
         e = exp_q.pop_front();
         checks++; if (bus.readdata !== e) begin errors++; $display("FAIL postrst_read[%0d] got %h exp %h", i, bus.readdata, e); end
         checks++; if (pulse_port !== exp_p) begin errors++; $display("FAIL postrst_pulse[%0d] got %h exp %h", i, pulse_port, exp_p); end
      end
   endtask

   initial begin
      test_reset();
      test_data_write();
      test_set_clear();
      test_pulse();
      test_retrigger();
      test_reset_mid_pulse();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end
endmodule
